// File: rtl/jtag_pa_pkg.sv
// Shared definitions for the JTAG host: scan width, host states, step counts and scan-step helpers.
// Steps are numbered from 1 within a scan; step 0 is the idle-to-scan handoff cycle.
package jtag_pa;
   localparam int REG_W        = 8;
   localparam int RESET_STEPS  = 5;
   localparam int DR_PRE_STEPS = 3;
   localparam int IR_PRE_STEPS = 4;
   localparam int POST_STEPS   = 2;
   localparam int STEP_W       = $clog2(REG_W + 7);
   localparam int IDX_W        = $clog2(REG_W);

   typedef enum logic [1:0] {RESET_SEQ, IDLE, SCAN} host_state_e;

   // Position inside the shift window; outside [0, REG_W) the step is not a shift step.
   function automatic int shift_idx(input logic is_ir, input logic [STEP_W-1:0] step);
      return int'(step) - 1 - (is_ir ? IR_PRE_STEPS : DR_PRE_STEPS);
   endfunction

   function automatic logic scan_tms(input logic is_ir, input logic [STEP_W-1:0] step);
      int i;
      int k;
      i = int'(step) - 1;
      k = shift_idx(is_ir, step);
      if (k < 0) return is_ir ? (i < 2) : (i == 0);
      if (k < REG_W) return k == REG_W - 1;
      return k == REG_W;
   endfunction

   function automatic logic [STEP_W-1:0] last_step(input logic is_ir);
      return STEP_W'((is_ir ? IR_PRE_STEPS : DR_PRE_STEPS) + REG_W + POST_STEPS);
   endfunction
endpackage

// File: rtl/jtag_host.sv
// JTAG initiator: one IR/DR scan per accepted request, TCK = i_clk/2, TDI/TDO MSB first; o_ready low while scanning.
// Optional active-low TAP reset pin o_trst_n when JTAG_HOST_TRST_EN is defined.
module jtag_host
   import jtag_pa::*;
(
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_valid,
   output logic             o_ready,
   input  logic             i_isIr,
   input  logic [REG_W-1:0] i_data,
   output logic             o_rspValid,
   output logic [REG_W-1:0] o_rspData,
   output logic             o_tck,
   output logic             o_tms,
   output logic             o_tdi,
`ifdef JTAG_HOST_TRST_EN
   output logic             o_trst_n,
`endif
   input  logic             i_tdo
);

   host_state_e       state_q, state_d;
   logic [STEP_W-1:0] step_q, step_d, step_nxt;
   logic              phase_q, phase_d;
   logic              tck_q, tck_d;
   logic              tms_q, tms_d;
   logic              tdi_q, tdi_d;
   logic              ready_q, ready_d;
   logic              rsp_vld_q, rsp_vld_d;
   logic [REG_W-1:0]  rsp_dat_q, rsp_dat_d;
   logic [REG_W-1:0]  cap_q, cap_d;
   logic              is_ir_q, is_ir_d;
   logic [REG_W-1:0]  data_q, data_d;
   int                cur_idx;
   int                nxt_idx;

   always_comb begin
      state_d   = state_q;
      step_d    = step_q;
      phase_d   = phase_q;
      tck_d     = tck_q;
      tms_d     = tms_q;
      tdi_d     = tdi_q;
      ready_d   = ready_q;
      rsp_vld_d = 1'b0;
      rsp_dat_d = rsp_dat_q;
      cap_d     = cap_q;
      is_ir_d   = is_ir_q;
      data_d    = data_q;
      step_nxt  = step_q + STEP_W'(1);
      cur_idx   = shift_idx(is_ir_q, step_q);
      nxt_idx   = shift_idx(is_ir_q, step_nxt);
      case (state_q)
         RESET_SEQ: begin
            phase_d = ~phase_q;
            tck_d   = ~phase_q;
            if (phase_q) begin
               if (step_q == STEP_W'(RESET_STEPS)) begin
                  state_d = IDLE;
                  ready_d = 1'b1;
                  tms_d   = 1'b0;
               end else begin
                  step_d = step_nxt;
                  tms_d  = step_nxt < STEP_W'(RESET_STEPS);
               end
            end
         end
         IDLE: begin
            tck_d = 1'b0;
            tms_d = 1'b0;
            tdi_d = 1'b0;
            // Entering with phase high makes the next edge load step 1's LOW phase.
            if (i_valid && ready_q) begin
               state_d = SCAN;
               ready_d = 1'b0;
               is_ir_d = i_isIr;
               data_d  = i_data;
               step_d  = '0;
               phase_d = 1'b1;
            end
         end
         SCAN: begin
            phase_d = ~phase_q;
            tck_d   = ~phase_q;
            if (!phase_q) begin
               if (cur_idx >= 0 && cur_idx < REG_W) cap_d = {cap_q[REG_W-2:0], i_tdo};
            end else if (step_q == last_step(is_ir_q)) begin
               state_d   = IDLE;
               ready_d   = 1'b1;
               rsp_vld_d = 1'b1;
               rsp_dat_d = cap_q;
               tms_d     = 1'b0;
               tdi_d     = 1'b0;
            end else begin
               step_d = step_nxt;
               tms_d  = scan_tms(is_ir_q, step_nxt);
               tdi_d  = (nxt_idx >= 0 && nxt_idx < REG_W) ? data_q[IDX_W'(REG_W - 1 - nxt_idx)] : 1'b0;
            end
         end
         default: state_d = RESET_SEQ;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q   <= RESET_SEQ;
         step_q    <= '0;
         phase_q   <= 1'b0;
         tck_q     <= 1'b0;
         tms_q     <= 1'b1;
         tdi_q     <= 1'b0;
         ready_q   <= 1'b0;
         rsp_vld_q <= 1'b0;
         rsp_dat_q <= '0;
         cap_q     <= '0;
         is_ir_q   <= 1'b0;
         data_q    <= '0;
      end else begin
         state_q   <= state_d;
         step_q    <= step_d;
         phase_q   <= phase_d;
         tck_q     <= tck_d;
         tms_q     <= tms_d;
         tdi_q     <= tdi_d;
         ready_q   <= ready_d;
         rsp_vld_q <= rsp_vld_d;
         rsp_dat_q <= rsp_dat_d;
         cap_q     <= cap_d;
         is_ir_q   <= is_ir_d;
         data_q    <= data_d;
      end
   end

`ifdef JTAG_HOST_TRST_EN
   logic trst_q, trst_d;

   // Released when the reset sequence moves from its second step into its third.
   assign trst_d = trst_q | (state_q == RESET_SEQ && phase_q && step_q == STEP_W'(1));

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) trst_q <= 1'b0;
      else       trst_q <= trst_d;
   end

   assign o_trst_n = trst_q;
`endif

   assign o_ready    = ready_q;
   assign o_rspValid = rsp_vld_q;
   assign o_rspData  = rsp_dat_q;
   assign o_tck      = tck_q;
   assign o_tms      = tms_q;
   assign o_tdi      = tdi_q;

endmodule

// File: tb/tb_jtag_host.sv
// Bench for jtag_host: TAP state machine + shift registers on the pins, and a timeline model of the host.
// Directed scans from the test plan, then randomized scans with occasional mid-scan resets.
module tb_jtag_host;
   localparam int W = jtag_pa::REG_W;

   logic         i_clk = 1'b0;
   logic         i_rst = 1'b1;
   logic         i_valid = 1'b0;
   logic         i_isIr = 1'b0;
   logic [W-1:0] i_data = '0;
   logic         i_tdo;
   logic         o_ready, o_rspValid, o_tck, o_tms, o_tdi;
   logic [W-1:0] o_rspData;
`ifdef JTAG_HOST_TRST_EN
   logic         o_trst_n;
`endif

   jtag_host dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
      .i_isIr(i_isIr), .i_data(i_data), .o_rspValid(o_rspValid), .o_rspData(o_rspData),
      .o_tck(o_tck), .o_tms(o_tms), .o_tdi(o_tdi),
`ifdef JTAG_HOST_TRST_EN
      .o_trst_n(o_trst_n),
`endif
      .i_tdo(i_tdo)
   );

   always #5 i_clk = ~i_clk;

   int n_vec = 0;
   int n_err = 0;
   int cyc = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // ---------------- TAP model ----------------
   typedef enum int {TLR, RTI, SELDR, CAPDR, SHDR, EX1DR, PADR, EX2DR, UPDR,
                     SELIR, CAPIR, SHIR, EX1IR, PAIR, EX2IR, UPIR} tap_e;
   tap_e         tap_st = SHDR;
   logic [W-1:0] tap_dr_sr = '0, tap_ir_sr = '0, tap_dr_upd = '0, tap_ir = '0, tap_dr_cap = '0;
   logic [W-1:0] ir_cap_val;
   assign ir_cap_val = W'(1);

   function automatic tap_e tap_next(input tap_e s, input logic tms);
      case (s)
         TLR:   return tms ? TLR   : RTI;
         RTI:   return tms ? SELDR : RTI;
         SELDR: return tms ? SELIR : CAPDR;
         CAPDR: return tms ? EX1DR : SHDR;
         SHDR:  return tms ? EX1DR : SHDR;
         EX1DR: return tms ? UPDR  : PADR;
         PADR:  return tms ? EX2DR : PADR;
         EX2DR: return tms ? UPDR  : SHDR;
         UPDR:  return tms ? SELDR : RTI;
         SELIR: return tms ? TLR   : CAPIR;
         CAPIR: return tms ? EX1IR : SHIR;
         SHIR:  return tms ? EX1IR : SHIR;
         EX1IR: return tms ? UPIR  : PAIR;
         PAIR:  return tms ? EX2IR : PAIR;
         EX2IR: return tms ? UPIR  : SHIR;
         default: return tms ? SELDR : RTI;
      endcase
   endfunction

   task automatic tap_clock(input logic tms, input logic tdi);
      case (tap_st)
         CAPDR: tap_dr_sr  = tap_dr_cap;
         SHDR:  tap_dr_sr  = {tap_dr_sr[W-2:0], tdi};
         UPDR:  tap_dr_upd = tap_dr_sr;
         CAPIR: tap_ir_sr  = ir_cap_val;
         SHIR:  tap_ir_sr  = {tap_ir_sr[W-2:0], tdi};
         UPIR:  tap_ir     = tap_ir_sr;
         default: ;
      endcase
      tap_st = tap_next(tap_st, tms);
   endtask

   assign i_tdo = (tap_st == SHDR) ? tap_dr_sr[W-1] : (tap_st == SHIR) ? tap_ir_sr[W-1] : 1'b0;

   // ---------------- host timeline model ----------------
   typedef enum int {M_RST, M_IDLE, M_SCAN} mode_e;
   mode_e        mode = M_RST;
   int           mj = 0;
   int           m_n = 0;
   logic         m_ir = 1'b0;
   logic         m_vld = 1'b0;
   logic [W-1:0] m_data = '0, m_exp = '0, m_rsp = '0;
   logic         tms_seq[$];
   logic         tdi_seq[$];
   logic [31:0]  tms_hist = '0;
   logic         tck_prev = 1'b0;

   always @(posedge i_clk) begin
      logic e_rdy, e_tck, e_tms, e_tdi;
      int k;
      cyc++;
      #1;
      if (o_tck && !tck_prev) begin
         tms_hist = {tms_hist[30:0], o_tms};
         tap_clock(o_tms, o_tdi);
      end
      tck_prev = o_tck;
`ifdef JTAG_HOST_TRST_EN
      if (!o_trst_n) tap_st = TLR;
`endif
      m_vld = 1'b0;
      if (i_rst) begin
         mode  = M_RST;
         mj    = 0;
         m_rsp = '0;
      end else begin
         case (mode)
            M_RST: begin
               mj++;
               if (mj == 12) begin
                  mode = M_IDLE;
                  chk("tap_rti_after_reset", 32'(tap_st), 32'(RTI));
               end
            end
            M_IDLE: if (i_valid) begin
               mode   = M_SCAN;
               mj     = 0;
               m_ir   = i_isIr;
               m_data = i_data;
               m_exp  = i_isIr ? ir_cap_val : tap_dr_cap;
               tms_seq.delete();
               tdi_seq.delete();
               tms_seq.push_back(1'b1);
               if (i_isIr) tms_seq.push_back(1'b1);
               tms_seq.push_back(1'b0);
               tms_seq.push_back(1'b0);
               for (int p = 0; p < tms_seq.size(); p++) tdi_seq.push_back(1'b0);
               for (int b = W - 1; b >= 0; b--) begin
                  tms_seq.push_back(b == 0);
                  tdi_seq.push_back(i_data[b]);
               end
               tms_seq.push_back(1'b1); tdi_seq.push_back(1'b0);
               tms_seq.push_back(1'b0); tdi_seq.push_back(1'b0);
               m_n = tms_seq.size();
            end
            default: begin
               mj++;
               if (mj == 2 * m_n + 1) begin
                  mode  = M_IDLE;
                  m_vld = 1'b1;
                  m_rsp = m_exp;
                  chk("tap_rti_after_scan", 32'(tap_st), 32'(RTI));
                  if (m_ir) chk("tap_ir_update", 32'(tap_ir), 32'(m_data));
                  else      chk("tap_dr_update", 32'(tap_dr_upd), 32'(m_data));
               end
            end
         endcase
      end
      e_rdy = 1'b0; e_tck = 1'b0; e_tms = 1'b0; e_tdi = 1'b0;
      case (mode)
         M_RST: begin
            if (i_rst) e_tms = 1'b1;
            else begin
               e_tck = (mj % 2) == 1;
               e_tms = (mj / 2) < 5;
            end
         end
         M_IDLE: e_rdy = 1'b1;
         default: if (mj > 0) begin
            k     = (mj + 1) / 2;
            e_tck = (mj % 2) == 0;
            e_tms = tms_seq[k-1];
            e_tdi = tdi_seq[k-1];
         end
      endcase
      chk("ready", 32'(o_ready), 32'(e_rdy));
      chk("tck", 32'(o_tck), 32'(e_tck));
      chk("tms", 32'(o_tms), 32'(e_tms));
      chk("tdi", 32'(o_tdi), 32'(e_tdi));
      chk("rsp_valid", 32'(o_rspValid), 32'(m_vld));
      chk("rsp_data", 32'(o_rspData), 32'(m_rsp));
`ifdef JTAG_HOST_TRST_EN
      chk("trst_n", 32'(o_trst_n), 32'(!(i_rst || (mode == M_RST && mj < 4))));
`endif
   end

   // ---------------- driver ----------------
   task automatic wait_ready();
      int t = 0;
      while (!o_ready && t < 200) begin
         @(negedge i_clk);
         t++;
      end
      chk("ready_timeout", 32'(o_ready), 32'd1);
   endtask

   task automatic start_scan(input logic ir, input logic [W-1:0] d, input logic [W-1:0] cap, output int acc);
      wait_ready();
      tap_dr_cap = cap;
      i_isIr     = ir;
      i_data     = d;
      i_valid    = 1'b1;
      tms_hist   = '0;
      acc        = cyc + 1;
      @(negedge i_clk);
      i_valid = 1'b0;
   endtask

   task automatic wait_rsp(input int acc, output int lat, output logic [W-1:0] rsp);
      int t = 0;
      while (!o_rspValid && t < 100) begin
         @(negedge i_clk);
         t++;
      end
      chk("rsp_timeout", 32'(o_rspValid), 32'd1);
      lat = cyc - acc;
      rsp = o_rspData;
   endtask

   task automatic do_reset(input int hold);
      int rel;
      i_rst = 1'b1;
      #1;
      chk("rst_tck", 32'(o_tck), 32'd0);
      chk("rst_tms", 32'(o_tms), 32'd1);
      chk("rst_tdi", 32'(o_tdi), 32'd0);
      chk("rst_ready", 32'(o_ready), 32'd0);
      chk("rst_rsp_valid", 32'(o_rspValid), 32'd0);
      chk("rst_rsp_data", 32'(o_rspData), 32'd0);
`ifdef JTAG_HOST_TRST_EN
      chk("rst_trst_n", 32'(o_trst_n), 32'd0);
`endif
      repeat (hold) @(negedge i_clk);
      i_rst    = 1'b0;
      rel      = cyc;
      tms_hist = '0;
      wait_ready();
      chk("reset_seq_len", 32'(cyc - rel), 32'd12);
      chk("reset_seq_tms", 32'(tms_hist[5:0]), 32'b111110);
   endtask

   initial begin
      int acc, acc2, lat, r1;
      logic [W-1:0] rsp, d, cap;
      logic ir;
      @(negedge i_clk);
      do_reset(3);

      start_scan(1'b0, 8'hA5, 8'h3C, acc);
      wait_rsp(acc, lat, rsp);
      chk("dr_rsp", 32'(rsp), 32'h3C);
      chk("dr_latency", 32'(lat), 32'd27);
      chk("dr_tap_value", 32'(tap_dr_upd), 32'hA5);

      start_scan(1'b1, 8'h81, 8'h00, acc);
      wait_rsp(acc, lat, rsp);
      chk("ir_rsp", 32'(rsp), 32'h01);
      chk("ir_latency", 32'(lat), 32'd29);
      chk("ir_tms_seq", 32'(tms_hist[13:0]), 32'b11000000000110);
      chk("ir_tap_value", 32'(tap_ir), 32'h81);

      wait_ready();
      tap_dr_cap = 8'h96;
      i_isIr     = 1'b0;
      i_data     = 8'hFF;
      i_valid    = 1'b1;
      acc        = cyc + 1;
      @(negedge i_clk);
      i_data = 8'h00;
      wait_rsp(acc, lat, rsp);
      r1   = cyc;
      acc2 = cyc + 1;
      chk("b2b_rsp1", 32'(rsp), 32'h96);
      chk("b2b_lat1", 32'(lat), 32'd27);
      @(negedge i_clk);
      i_valid = 1'b0;
      wait_rsp(acc2, lat, rsp);
      chk("b2b_rsp2", 32'(rsp), 32'h96);
      chk("b2b_lat2", 32'(lat), 32'd27);
      chk("b2b_spacing", 32'(cyc - r1), 32'd28);
      chk("b2b_tap_value", 32'(tap_dr_upd), 32'h00);

      start_scan(1'b0, 8'h5A, 8'hC3, acc);
      repeat (15) @(negedge i_clk);
      do_reset(2);
      start_scan(1'b0, 8'h3C, 8'hA5, acc);
      wait_rsp(acc, lat, rsp);
      chk("post_reset_rsp", 32'(rsp), 32'hA5);
      chk("post_reset_tap", 32'(tap_dr_upd), 32'h3C);

      for (int i = 0; i < 40; i++) begin
         repeat ($urandom_range(0, 3)) @(negedge i_clk);
         ir  = 1'($urandom_range(0, 1));
         d   = W'($urandom);
         cap = W'($urandom);
         start_scan(ir, d, cap, acc);
         if ($urandom_range(0, 7) == 0) begin
            repeat ($urandom_range(0, 25)) @(negedge i_clk);
            do_reset(int'($urandom_range(1, 3)));
         end else begin
            wait_rsp(acc, lat, rsp);
            chk("rnd_rsp", 32'(rsp), ir ? 32'h01 : 32'(cap));
            chk("rnd_latency", 32'(lat), ir ? 32'd29 : 32'd27);
         end
      end

      repeat (4) @(negedge i_clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: bench did not finish, %0d vectors, %0d miscompares", n_vec, n_err);
      $fatal(1);
   end
endmodule
